tlp_tx_serializer: RTL and testbench
====================================

# tlp_tx_serializer

- Converts one memory-request descriptor plus its payload stream into a 32-bit DW stream with sop/eop framing.
- Emits a 3DW-header MRd32/MWr32 TLP: three header DWs, then, for writes, the payload DWs.
- Sits directly upstream of the transmit skid buffer. Its output register drives the skid buffer's input valid/data, and the skid buffer's upstream ready drives `i_ready`.
- Output obeys valid-stability: once `o_valid` is high, `o_data`/`o_sop`/`o_eop` hold until accepted.

## Interface

Parameters:
- `DATA_WIDTH`, 32 — DW width; only 32 supported.
- `LEN_WIDTH`, 10 — TLP Length field width; value 0 encodes 1024 DW.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  — sole clock, all logic on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  1  — descriptor present.
- `req_ready`  out  1  — descriptor accepted this cycle when both high.
- `req_wr`  in  1  — 1 = MWr32, 0 = MRd32.
- `req_len`  in  LEN_WIDTH  — length in DW.
- `req_addr`  in  32  — byte address; bits [1:0] ignored.
- `req_id`  in  16  — requester ID.
- `req_tag`  in  8  — tag.
- `req_fbe`, `req_lbe`  in  4 each  — first/last byte enables.
- `pl_valid`  in  1  — payload DW present.
- `pl_ready`  out  1  — payload DW consumed when both high.
- `pl_data`  in  DATA_WIDTH  — payload DW.
- `o_valid`  out  1  — output DW valid (registered).
- `o_data`  out  DATA_WIDTH  — output DW (registered).
- `o_sop`, `o_eop`  out  1 each  — first/last DW of TLP (registered).
- `i_ready`  in  1  — downstream (skid buffer) ready.

## Operation

- `adv = !o_valid || i_ready`. The output register loads only when `adv` is high. When `adv` is low, everything holds.
- FSM states: IDLE, H1, H2, DATA.
- IDLE:
  - `req_ready = adv`.
  - On `req_valid && adv`: capture descriptor, load DW0, set sop=1, go to H1.
  - On `adv` with no request: `o_valid <= 0`.
- H1: on `adv`, load DW1 = {id[15:0], tag[7:0], lbe, fbe}; go to H2.
- H2: on `adv`, load DW2 = {addr[31:2], 2'b00}.
  - Read: eop=1, go to IDLE.
  - Write: load `dw_rem` = (len==0 ? 1024 : len); go to DATA.
- DATA:
  - `pl_ready = adv`.
  - On `adv && pl_valid`: load `pl_data`, decrement `dw_rem`. If `dw_rem` was 1: eop=1, go to IDLE.
  - On `adv && !pl_valid`: `o_valid <= 0` (bubble); stay in DATA.
- DW0 fields:
  - fmt[31:29] = {1'b0, req_wr, 1'b0}.
  - type[28:24] = 5'b00000.
  - TC/TD/EP/attr/AT = 0.
  - length[9:0] = req_len.
- `dw_rem` is 11 bits, so 1024 is representable; no wrap.
- `pl_ready` is 0 outside DATA. `req_ready` is 0 outside IDLE.
- Payload arriving before DATA is not consumed.
- `req_lbe` is passed through unchecked; the requester guarantees lbe=0 when len=1.

## Timing

- Reset values: `o_valid`=0, `o_data`=0, `o_sop`=0, `o_eop`=0, state=IDLE, `dw_rem`=0.
  - Combinational consequences: `req_ready`=1, `pl_ready`=0.
- Reset mid-TLP: the partial TLP is dropped and no eop is emitted. The next cycle is a clean IDLE.
- Latency: descriptor accepted in cycle N → DW0 valid at N+1.
- With `i_ready` held high:
  - MRd occupies 3 consecutive output cycles.
  - MWr len=L occupies 3+L cycles, provided `pl_valid` stays high.
- Back-to-back: a new descriptor is accepted in the same cycle the eop DW is accepted. DW0 of the next TLP follows with zero bubble.
- `i_ready` low with `o_valid` high: all outputs frozen; `req_ready`/`pl_ready` are 0.
- `o_sop` is high only on DW0; `o_eop` only on the final DW. Both are 0 when `o_valid`=0.

## Structure

- Package `pcie_tlp_pkg` holds:
  - fmt/type constants (FMT_3DW_NODATA, FMT_3DW_DATA, TYPE_MEM).
  - The FSM enum `tx_ser_state_t`.
  - Header-packing functions `tlp_dw0()` and `tlp_dw1()`.
- The block is a single module with no sub-module. The FSM, counter and output register are small and tightly coupled.

## Test plan

- Reset then MRd, len=1, addr=0x1000_0004, id=0x0100, tag=0x05, fbe=0xF, `i_ready`=1 → three cycles of output:
  - 0x0000_0001 (sop)
  - 0x0100_050F
  - 0x1000_0004 (eop)
- MWr len=4, payload 0xA0..0xA3, `i_ready`=1 → 7 DWs, DW0=0x4000_0004, eop on 0xA3, `pl_ready` high for exactly 4 cycles.
- MWr len=2 with `i_ready` toggling 1,0,0,1,… → every DW held stable while stalled; no duplication or loss; order matches.
- MWr len=3 with `pl_valid` low for 2 cycles after the first payload DW → 2 cycles of `o_valid`=0 mid-packet; eop still on the 3rd payload DW.
- MWr len=0 → DW0 length field 0; 1024 payload DWs emitted; eop on the 1024th; then IDLE.
- Two MRd descriptors back-to-back, then `rst` asserted during H1 of the second → first TLP intact; all outputs 0 the cycle after reset; `req_ready`=1.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// Shared TLP definitions for the transmit path: header format/type codes,
// the serializer FSM encoding and the 3DW header packing helpers.
package pcie_tlp_pkg;

    // Fmt codes for 3DW headers, with and without a data payload
    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;

    // Type code shared by MRd and MWr; Fmt alone tells them apart
    localparam logic [4:0] TYPE_MEM = 5'b00000;

    // Payload DW counter width: wide enough to hold 1024 without wrapping
    localparam int unsigned REM_WIDTH = 11;
    localparam logic [REM_WIDTH-1:0] MAX_PAYLOAD_DW = 11'd1024;

    // Serializer FSM: IDLE emits DW0, H1 emits DW1, H2 emits DW2, DATA emits payload
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_H1   = 2'd1,
        ST_H2   = 2'd2,
        ST_DATA = 2'd3
    } tx_ser_state_t;

    // DW0: Fmt, Type, zero TC/TD/EP/Attr/AT, then the 10-bit Length field
    function automatic logic [31:0] tlp_dw0(input logic wr, input logic [9:0] len);
        return {(wr ? FMT_3DW_DATA : FMT_3DW_NODATA), TYPE_MEM, 14'd0, len};
    endfunction

    // DW1: Requester ID, Tag, Last BE, First BE
    function automatic logic [31:0] tlp_dw1(input logic [15:0] id, input logic [7:0] tag,
                                            input logic [3:0] lbe, input logic [3:0] fbe);
        return {id, tag, lbe, fbe};
    endfunction

endpackage

// File: rtl/tlp_tx_serializer.sv
// Serializes one MRd32/MWr32 descriptor plus its payload into a framed 32-bit
// DW stream feeding the transmit skid buffer.
//
// Handshake: every interface transfers on the rising edge where valid and
// ready are both high. o_valid/o_data/o_sop/o_eop are registered and stay
// unchanged while o_valid is high and i_ready is low. req_ready and pl_ready
// are combinational and are only ever high when the output register is free
// to load (adv), so a transfer on either input always lands in o_data.
module tlp_tx_serializer
    import pcie_tlp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [31:0]           req_addr,
    input  logic [15:0]           req_id,
    input  logic [7:0]            req_tag,
    input  logic [3:0]            req_fbe,
    input  logic [3:0]            req_lbe,

    input  logic                  pl_valid,
    output logic                  pl_ready,
    input  logic [DATA_WIDTH-1:0] pl_data,

    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_sop,
    output logic                  o_eop,
    input  logic                  i_ready
);

    tx_ser_state_t          state_q, state_d;
    logic [REM_WIDTH-1:0]   dw_rem_q, dw_rem_d;

    logic                   o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0]  o_data_q, o_data_d;
    logic                   o_sop_q, o_sop_d;
    logic                   o_eop_q, o_eop_d;

    // Descriptor fields still needed after DW0 has gone out
    logic                   wr_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [29:0]            addr_q;
    logic [15:0]            id_q;
    logic [7:0]             tag_q;
    logic [3:0]             fbe_q;
    logic [3:0]             lbe_q;
    logic                   capture;

    logic                   adv;

    // Address is DW-aligned; the byte offset bits carry no information here
    logic                   addr_lo_unused;
    assign addr_lo_unused = ^req_addr[1:0];

    // The output register may load when it is empty or being drained this cycle
    assign adv = !o_valid_q || i_ready;

    // Next-state, output-register load and handshake readies
    always_comb begin
        state_d   = state_q;
        dw_rem_d  = dw_rem_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_sop_d   = o_sop_q;
        o_eop_d   = o_eop_q;
        capture   = 1'b0;
        req_ready = 1'b0;
        pl_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = adv;
                if (adv) begin
                    if (req_valid) begin
                        capture   = 1'b1;
                        o_valid_d = 1'b1;
                        o_data_d  = tlp_dw0(req_wr, req_len);
                        o_sop_d   = 1'b1;
                        o_eop_d   = 1'b0;
                        state_d   = ST_H1;
                    end else begin
                        o_valid_d = 1'b0;
                        o_sop_d   = 1'b0;
                        o_eop_d   = 1'b0;
                    end
                end
            end

            ST_H1: begin
                if (adv) begin
                    o_valid_d = 1'b1;
                    o_data_d  = tlp_dw1(id_q, tag_q, lbe_q, fbe_q);
                    o_sop_d   = 1'b0;
                    o_eop_d   = 1'b0;
                    state_d   = ST_H2;
                end
            end

            ST_H2: begin
                if (adv) begin
                    o_valid_d = 1'b1;
                    o_data_d  = {addr_q, 2'b00};
                    o_sop_d   = 1'b0;
                    if (wr_q) begin
                        // A zero Length field means the maximum payload
                        o_eop_d  = 1'b0;
                        dw_rem_d = (len_q == '0) ? MAX_PAYLOAD_DW : REM_WIDTH'(len_q);
                        state_d  = ST_DATA;
                    end else begin
                        o_eop_d  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                pl_ready = adv;
                if (adv) begin
                    o_sop_d = 1'b0;
                    if (pl_valid) begin
                        o_valid_d = 1'b1;
                        o_data_d  = pl_data;
                        dw_rem_d  = dw_rem_q - 1'b1;
                        if (dw_rem_q == REM_WIDTH'(1)) begin
                            o_eop_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            o_eop_d = 1'b0;
                        end
                    end else begin
                        // Payload source starved: emit a bubble, keep the packet open
                        o_valid_d = 1'b0;
                        o_eop_d   = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, payload counter and output register; reset drops any partial TLP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dw_rem_q  <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_sop_q   <= 1'b0;
            o_eop_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dw_rem_q  <= dw_rem_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_sop_q   <= o_sop_d;
            o_eop_q   <= o_eop_d;
        end
    end

    // Descriptor holding registers, loaded when the request is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= 1'b0;
            len_q  <= '0;
            addr_q <= '0;
            id_q   <= '0;
            tag_q  <= '0;
            fbe_q  <= '0;
            lbe_q  <= '0;
        end else if (capture) begin
            wr_q   <= req_wr;
            len_q  <= req_len;
            addr_q <= req_addr[31:2];
            id_q   <= req_id;
            tag_q  <= req_tag;
            fbe_q  <= req_fbe;
            lbe_q  <= req_lbe;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_sop   = o_sop_q;
    assign o_eop   = o_eop_q;

endmodule

// File: tb/tb_tlp_tx_serializer.sv
// Directed bench for tlp_tx_serializer: descriptor/payload drivers, an
// in-order scoreboard of {sop, eop, data} beats, and a stall/framing monitor.
module tb_tlp_tx_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [9:0]  req_len;
  logic [31:0] req_addr;
  logic [15:0] req_id;
  logic [7:0]  req_tag;
  logic [3:0]  req_fbe;
  logic [3:0]  req_lbe;
  logic        pl_valid;
  logic        pl_ready;
  logic [31:0] pl_data;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_sop;
  logic        o_eop;
  logic        i_ready;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  tlp_tx_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_len   (req_len),
    .req_addr  (req_addr),
    .req_id    (req_id),
    .req_tag   (req_tag),
    .req_fbe   (req_fbe),
    .req_lbe   (req_lbe),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_sop     (o_sop),
    .o_eop     (o_eop),
    .i_ready   (i_ready)
  );

  typedef struct packed {
    logic        wr;
    logic [9:0]  len;
    logic [31:0] addr;
    logic [15:0] id;
    logic [7:0]  tag;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
  } desc_t;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [33:0] exp_q[$];
  logic [31:0] pl_q[$];
  desc_t       desc_q[$];

  // run metrics
  int          first_out;
  int          last_out;
  int          fire_cyc;
  int          n_acc;
  int          n_sop_acc;
  int          pl_rdy_cnt;
  int          bubble_cnt;
  logic        stall_prev;
  logic [33:0] hold_beat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_metrics();
    first_out  = -1;
    last_out   = -1;
    fire_cyc   = -1;
    n_acc      = 0;
    n_sop_acc  = 0;
    pl_rdy_cnt = 0;
    bubble_cnt = 0;
    stall_prev = 1'b0;
    hold_beat  = '0;
  endtask

  // Expected beats of a full TLP built from the descriptor fields
  task automatic exp_tlp(input desc_t d, input logic [31:0] pl_base);
    int n;
    n = d.wr ? ((d.len == 10'd0) ? 1024 : int'(d.len)) : 0;
    exp_q.push_back({1'b1, 1'b0, 1'b0, d.wr, 1'b0, 5'b00000, 14'd0, d.len});
    exp_q.push_back({2'b00, d.id, d.tag, d.lbe, d.fbe});
    exp_q.push_back({1'b0, !d.wr, d.addr[31:2], 2'b00});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, (i == n - 1), pl_base + 32'(i)});
      pl_q.push_back(pl_base + 32'(i));
    end
    desc_q.push_back(d);
  endtask

  // Output monitor, called once per cycle with inputs already settled
  task automatic observe(input int cyc);
    logic [33:0] e;
    if (!o_valid) check_eq("flags_when_invalid", {62'd0, o_sop, o_eop}, 64'd0);
    if (stall_prev)
      check_eq("held_beat", {29'd0, o_valid, o_sop, o_eop, o_data}, {29'd0, 1'b1, hold_beat});
    if (o_valid && !i_ready)
      check_eq("readies_in_stall", {62'd0, req_ready, pl_ready}, 64'd0);
    if (pl_ready) pl_rdy_cnt++;
    if (!o_valid && first_out >= 0 && exp_q.size() > 0) bubble_cnt++;
    if (o_valid && i_ready) begin
      check_eq("beat_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("beat", {30'd0, o_sop, o_eop, o_data}, {30'd0, e});
      end
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      n_acc++;
      if (o_sop) n_sop_acc++;
    end
    stall_prev = o_valid && !i_ready && !rst;
    hold_beat  = {o_sop, o_eop, o_data};
  endtask

  // Driver: feeds queued descriptors and payload until every expected beat
  // is accepted. ready_mode 0 = always ready, 1 = pattern 1,0,0 repeating.
  // gap_after_first inserts pl_valid-low cycles after the first payload DW.
  // reset_mid asserts rst while the second TLP's DW0 is on the output.
  task automatic run_seq(input int ready_mode, input int gap_after_first, input bit reset_mid);
    int  cyc;
    int  gap_left;
    bit  gap_done;
    bit  done;
    cyc = 0;
    gap_left = 0;
    gap_done = 1'b0;
    done = 1'b0;
    clear_metrics();
    while (!done && cyc < 3000) begin
      @(negedge clk);
      i_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (desc_q.size() > 0) begin
        req_valid = 1'b1;
        req_wr    = desc_q[0].wr;
        req_len   = desc_q[0].len;
        req_addr  = desc_q[0].addr;
        req_id    = desc_q[0].id;
        req_tag   = desc_q[0].tag;
        req_fbe   = desc_q[0].fbe;
        req_lbe   = desc_q[0].lbe;
      end else begin
        req_valid = 1'b0;
      end
      if (pl_q.size() > 0) pl_data = pl_q[0];
      if (gap_left > 0) begin
        pl_valid = 1'b0;
        gap_left--;
      end else begin
        pl_valid = (pl_q.size() > 0);
      end
      if (reset_mid && o_valid && o_sop && n_sop_acc == 1) begin
        rst       = 1'b1;
        req_valid = 1'b0;
        pl_valid  = 1'b0;
      end
      #1;
      observe(cyc);
      if (req_valid && req_ready) begin
        void'(desc_q.pop_front());
        if (fire_cyc < 0) fire_cyc = cyc;
      end
      if (pl_valid && pl_ready) begin
        void'(pl_q.pop_front());
        if (!gap_done && gap_after_first > 0) begin
          gap_left = gap_after_first;
          gap_done = 1'b1;
        end
      end
      if (rst) done = 1'b1;
      if (desc_q.size() == 0 && pl_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
      cyc++;
    end
    check_eq("exp_left_at_end", 64'(exp_q.size()), 64'd0);
    check_eq("desc_left_at_end", 64'(desc_q.size()), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      pl_valid  = 1'b0;
      i_ready   = 1'b1;
      #1;
      observe(1000000 + i);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_o_valid"}, {63'd0, o_valid}, 64'd0);
    check_eq({tag, "_o_data"}, {32'd0, o_data}, 64'd0);
    check_eq({tag, "_sop_eop"}, {62'd0, o_sop, o_eop}, 64'd0);
    check_eq({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    check_eq({tag, "_pl_ready"}, {63'd0, pl_ready}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    pl_valid  = 1'b0;
    i_ready   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    clear_metrics();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    desc_t d;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_len = '0; req_addr = '0;
    req_id = '0; req_tag = '0; req_fbe = '0; req_lbe = '0;
    pl_valid = 1'b0; pl_data = '0; i_ready = 1'b1;

    // Reset state
    do_reset();
    check_reset_state("reset");

    // MRd len=1, hand-computed header beats
    d = '{wr: 1'b0, len: 10'd1, addr: 32'h1000_0004, id: 16'h0100, tag: 8'h05, fbe: 4'hF, lbe: 4'h0};
    desc_q.push_back(d);
    exp_q.push_back({2'b10, 32'h0000_0001});
    exp_q.push_back({2'b00, 32'h0100_050F});
    exp_q.push_back({2'b01, 32'h1000_0004});
    run_seq(0, 0, 1'b0);
    check_eq("mrd_latency", 64'(first_out - fire_cyc), 64'd1);
    check_eq("mrd_span", 64'(last_out - first_out), 64'd2);
    check_eq("mrd_beats", 64'(n_acc), 64'd3);
    idle(3);

    // MWr len=4, payload A0..A3
    d = '{wr: 1'b1, len: 10'd4, addr: 32'h2000_0010, id: 16'h0200, tag: 8'h11, fbe: 4'hF, lbe: 4'hF};
    desc_q.push_back(d);
    exp_q.push_back({2'b10, 32'h4000_0004});
    exp_q.push_back({2'b00, 32'h0200_11FF});
    exp_q.push_back({2'b00, 32'h2000_0010});
    exp_q.push_back({2'b00, 32'h0000_00A0});
    exp_q.push_back({2'b00, 32'h0000_00A1});
    exp_q.push_back({2'b00, 32'h0000_00A2});
    exp_q.push_back({2'b01, 32'h0000_00A3});
    for (int i = 0; i < 4; i++) pl_q.push_back(32'h0000_00A0 + 32'(i));
    run_seq(0, 0, 1'b0);
    check_eq("mwr4_beats", 64'(n_acc), 64'd7);
    check_eq("mwr4_span", 64'(last_out - first_out), 64'd6);
    check_eq("mwr4_pl_ready_cycles", 64'(pl_rdy_cnt), 64'd4);
    idle(3);

    // MWr len=2 with downstream ready toggling
    d = '{wr: 1'b1, len: 10'd2, addr: 32'h0000_ABC8, id: 16'h1234, tag: 8'h7E, fbe: 4'h3, lbe: 4'hC};
    exp_tlp(d, 32'h5500_0000);
    run_seq(1, 0, 1'b0);
    check_eq("mwr2_stall_beats", 64'(n_acc), 64'd5);
    idle(3);

    // MWr len=3 with a two-cycle payload gap after the first DW
    d = '{wr: 1'b1, len: 10'd3, addr: 32'hFFFF_FFFC, id: 16'hBEEF, tag: 8'h80, fbe: 4'hF, lbe: 4'h1};
    exp_tlp(d, 32'h0BAD_F00D);
    run_seq(0, 2, 1'b0);
    check_eq("mwr3_bubbles", 64'(bubble_cnt), 64'd2);
    check_eq("mwr3_beats", 64'(n_acc), 64'd6);
    idle(3);

    // MWr len=0 -> 1024 payload DWs
    d = '{wr: 1'b1, len: 10'd0, addr: 32'h8000_0000, id: 16'h0001, tag: 8'hFF, fbe: 4'hF, lbe: 4'hF};
    exp_tlp(d, 32'hC000_0000);
    run_seq(0, 0, 1'b0);
    check_eq("mwr1024_beats", 64'(n_acc), 64'd1027);
    check_eq("mwr1024_span", 64'(last_out - first_out), 64'd1026);
    idle(3);

    // Two MRd back-to-back, reset while the second sits in H1
    d = '{wr: 1'b0, len: 10'd2, addr: 32'h3000_0008, id: 16'h0300, tag: 8'h21, fbe: 4'hF, lbe: 4'hF};
    exp_tlp(d, 32'h0);
    d = '{wr: 1'b0, len: 10'd1, addr: 32'h3000_0100, id: 16'h0300, tag: 8'h22, fbe: 4'hF, lbe: 4'h0};
    desc_q.push_back(d);
    exp_q.push_back({2'b10, 32'h0000_0001});
    run_seq(0, 0, 1'b1);
    check_eq("b2b_beats", 64'(n_acc), 64'd4);
    check_eq("b2b_span", 64'(last_out - first_out), 64'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    clear_metrics();
    idle(4);
    check_eq("post_reset_silence", 64'(n_acc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
